// File: rtl/serial_parity_checker_if.sv
// Serial parity link bundle: the sender drives the bit stream, the checker
// returns the decoded word, status pulses and the error tally.
interface serial_parity_checker_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              din;
    logic              din_valid;
    logic [DATA_W-1:0] data_out;
    logic              frame_done;
    logic              parity_err;
    logic              busy;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output start, din, din_valid,
        input  data_out, frame_done, parity_err, busy, err_count
    );

    modport slave (
        input  start, din, din_valid,
        output data_out, frame_done, parity_err, busy, err_count
    );
endinterface

// File: rtl/serial_parity_checker.sv
// Receive side of the XOR-parity serial link. Shifts in DATA_W payload bits
// MSB first followed by one parity bit, recomputes parity with a running XOR
// and keeps a saturating count of frames that failed the check.
module serial_parity_checker #(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_parity_checker_if.slave bus
);

    localparam int   CW  = $clog2(DATA_W + 1);
    localparam logic ODD = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [CW-1:0]     bit_cnt;
    logic              run_xor;
    logic [DATA_W-1:0] data_reg;
    logic              done_reg;
    logic              perr_reg;
    logic              busy_reg;
    logic [CNT_W-1:0]  err_reg;
    logic              chk;

    // Error counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Mismatch flag for the parity bit currently on the wire.
    assign chk = run_xor ^ bus.din ^ ODD;

    // Frame FSM with registered outputs; start always restarts a frame and
    // outranks a simultaneous din_valid, whose bit is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            run_xor   <= 1'b0;
            data_reg  <= '0;
            done_reg  <= 1'b0;
            perr_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            err_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            if (bus.start) begin
                state    <= DATA;
                bit_cnt  <= '0;
                run_xor  <= 1'b0;
                busy_reg <= 1'b1;
            end else begin
                case (state)
                    DATA: begin
                        if (bus.din_valid) begin
                            shift_reg <= {shift_reg[DATA_W-2:0], bus.din};
                            run_xor   <= run_xor ^ bus.din;
                            if (bit_cnt == CW'(DATA_W - 1)) begin
                                bit_cnt <= '0;
                                state   <= PARITY;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
                    PARITY: begin
                        if (bus.din_valid) begin
                            data_reg <= shift_reg;
                            perr_reg <= chk;
                            done_reg <= 1'b1;
                            if (chk) begin
                                err_reg <= sat_inc(err_reg);
                            end
                            state    <= IDLE;
                            busy_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        busy_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_out   = data_reg;
    assign bus.frame_done = done_reg;
    assign bus.parity_err = perr_reg;
    assign bus.busy       = busy_reg;
    assign bus.err_count  = err_reg;

endmodule
